// File: rtl/pkt_loopback.sv
// pkt_loopback: drains MAC receive frames into a small elastic FIFO and replays them on MAC transmit.
// Define PKT_LOOPBACK_STATS_EN to build the saturating frame / error-frame counters.
module pkt_loopback #(
   parameter int unsigned FIFO_AW = 4
) (
   input  logic        clk_156m25,
   input  logic        reset_156m25_n,
   input  logic        loopback_en,
   input  logic        pkt_rx_avail,
   output logic        pkt_rx_ren,
   input  logic        pkt_rx_val,
   input  logic        pkt_rx_sop,
   input  logic        pkt_rx_eop,
   input  logic        pkt_rx_err,
   input  logic [63:0] pkt_rx_data,
   input  logic [2:0]  pkt_rx_mod,
   input  logic        pkt_tx_full,
   output logic        pkt_tx_val,
   output logic        pkt_tx_sop,
   output logic        pkt_tx_eop,
   output logic [63:0] pkt_tx_data,
   output logic [2:0]  pkt_tx_mod,
   output logic        busy,
   output logic [31:0] stat_frames,
   output logic [31:0] stat_err_frames
);

   localparam int unsigned DEPTH = 2**FIFO_AW;
   localparam int unsigned CW    = FIFO_AW + 1;

   typedef struct packed {
      logic [63:0] data;
      logic        sop;
      logic        eop;
      logic [2:0]  mod;
      logic        err;
   } fifo_word_t;

   typedef enum logic {
      IDLE = 1'b0,
      READ = 1'b1
   } state_t;

   state_t             state;
   fifo_word_t         mem [DEPTH];
   fifo_word_t         wr_word;
   fifo_word_t         rd_word;
   logic [FIFO_AW-1:0] wr_ptr;
   logic [FIFO_AW-1:0] rd_ptr;
   logic [CW-1:0]      count;
   logic               push;
   logic               pop;
   logic               rx_eop_seen;

   assign rx_eop_seen = pkt_rx_val & pkt_rx_eop;
   assign push        = pkt_rx_val;
   assign pop         = (count != '0) & ~pkt_tx_full;
   assign wr_word     = '{data: pkt_rx_data, sop: pkt_rx_sop, eop: pkt_rx_eop,
                          mod: pkt_rx_mod, err: pkt_rx_err};
   assign rd_word     = mem[rd_ptr];

   // Threshold leaves room for the word already in flight plus this cycle's write.
   assign pkt_rx_ren = reset_156m25_n & (state == READ) & ~rx_eop_seen
                       & (count <= CW'(DEPTH - 3));
   assign busy       = (state != IDLE) | (count != '0);

   // Reader FSM: one frame per visit to READ, ended by the eop word.
   always_ff @(posedge clk_156m25) begin
      if (!reset_156m25_n) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE:    if (loopback_en && pkt_rx_avail) state <= READ;
            READ:    if (rx_eop_seen) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_156m25) begin
      if (push) mem[wr_ptr] <= wr_word;
   end

   // Pointers, occupancy and registered transmit stage.
   always_ff @(posedge clk_156m25) begin
      if (!reset_156m25_n) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         pkt_tx_val  <= 1'b0;
         pkt_tx_sop  <= 1'b0;
         pkt_tx_eop  <= 1'b0;
         pkt_tx_data <= '0;
         pkt_tx_mod  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
         if (pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
         count      <= count + CW'(push) - CW'(pop);
         pkt_tx_val <= pop;
         if (pop) begin
            pkt_tx_sop  <= rd_word.sop;
            pkt_tx_eop  <= rd_word.eop;
            pkt_tx_data <= rd_word.data;
            pkt_tx_mod  <= rd_word.mod;
         end
      end
   end

`ifdef PKT_LOOPBACK_STATS_EN
   // Saturating counters, updated as eop words leave the FIFO.
   always_ff @(posedge clk_156m25) begin
      if (!reset_156m25_n) begin
         stat_frames     <= '0;
         stat_err_frames <= '0;
      end else if (pop && rd_word.eop) begin
         if (stat_frames != '1) stat_frames <= stat_frames + 32'd1;
         if (rd_word.err && (stat_err_frames != '1)) stat_err_frames <= stat_err_frames + 32'd1;
      end
   end
`else
   logic unused_err;
   assign unused_err      = rd_word.err;
   assign stat_frames     = '0;
   assign stat_err_frames = '0;
`endif

endmodule

// File: tb/tb_pkt_loopback.sv
// Self-checking bench for pkt_loopback: a MAC rx responder, a word-level scoreboard and per-feature scenarios.
module tb_pkt_loopback;

   localparam int unsigned FIFO_AW = 4;
   localparam int          DEPTH   = 16;
`ifdef PKT_LOOPBACK_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   typedef struct packed {
      logic [63:0] data;
      logic        sop;
      logic        eop;
      logic [2:0]  mod;
      logic        err;
   } word_t;

   logic        clk = 1'b0;
   logic        reset_156m25_n;
   logic        loopback_en;
   logic        pkt_rx_avail;
   logic        pkt_rx_ren;
   logic        pkt_rx_val;
   logic        pkt_rx_sop;
   logic        pkt_rx_eop;
   logic        pkt_rx_err;
   logic [63:0] pkt_rx_data;
   logic [2:0]  pkt_rx_mod;
   logic        pkt_tx_full;
   logic        pkt_tx_val;
   logic        pkt_tx_sop;
   logic        pkt_tx_eop;
   logic [63:0] pkt_tx_data;
   logic [2:0]  pkt_tx_mod;
   logic        busy;
   logic [31:0] stat_frames;
   logic [31:0] stat_err_frames;

   pkt_loopback #(.FIFO_AW(FIFO_AW)) dut (
      .clk_156m25      (clk),
      .reset_156m25_n  (reset_156m25_n),
      .loopback_en     (loopback_en),
      .pkt_rx_avail    (pkt_rx_avail),
      .pkt_rx_ren      (pkt_rx_ren),
      .pkt_rx_val      (pkt_rx_val),
      .pkt_rx_sop      (pkt_rx_sop),
      .pkt_rx_eop      (pkt_rx_eop),
      .pkt_rx_err      (pkt_rx_err),
      .pkt_rx_data     (pkt_rx_data),
      .pkt_rx_mod      (pkt_rx_mod),
      .pkt_tx_full     (pkt_tx_full),
      .pkt_tx_val      (pkt_tx_val),
      .pkt_tx_sop      (pkt_tx_sop),
      .pkt_tx_eop      (pkt_tx_eop),
      .pkt_tx_data     (pkt_tx_data),
      .pkt_tx_mod      (pkt_tx_mod),
      .busy            (busy),
      .stat_frames     (stat_frames),
      .stat_err_frames (stat_err_frames)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   word_t       mac_q[$];
   word_t       exp_q[$];
   bit          m_reading;
   int          m_occ;
   bit          exp_txv;
   logic [63:0] last_data;
   logic        last_sop, last_eop;
   logic [2:0]  last_mod;
   int          exp_frames, exp_err_frames;
   bit          ren_s;
   int          first_rx_cyc, first_tx_cyc, first_ren_cyc, last_ren_cyc;
   int          tx_words, rx_words, ren_cycles, stall_cycles, eop_mod1;

   task automatic reset_counters();
      first_rx_cyc  = -1;
      first_tx_cyc  = -1;
      first_ren_cyc = -1;
      last_ren_cyc  = -1;
      tx_words      = 0;
      rx_words      = 0;
      ren_cycles    = 0;
      stall_cycles  = 0;
      eop_mod1      = 0;
   endtask

   task automatic add_frame(input int n, input logic [2:0] m, input logic e);
      word_t w;
      for (int i = 0; i < n; i++) begin
         w.data = {$urandom, $urandom};
         w.sop  = (i == 0);
         w.eop  = (i == n - 1);
         w.mod  = (i == n - 1) ? m : 3'd0;
         w.err  = (i == n - 1) ? e : 1'b0;
         mac_q.push_back(w);
      end
      pkt_rx_avail = (mac_q.size() > 0);
   endtask

   task automatic drive_idle();
      pkt_rx_val  = 1'b0;
      pkt_rx_sop  = 1'b0;
      pkt_rx_eop  = 1'b0;
      pkt_rx_err  = 1'b0;
      pkt_rx_mod  = 3'd0;
      pkt_rx_data = {$urandom, $urandom};
   endtask

   // One clock: observe at negedge against the model, then let the MAC answer the read.
   task automatic cycle();
      word_t w;
      bit    pop_now, exp_ren;
      @(negedge clk);
      checks++;
      if (pkt_tx_val !== exp_txv) begin
         errors++;
         $display("FAIL tx_val cyc=%0d: got %b, expected %b", cyc, pkt_tx_val, exp_txv);
      end
      if (pkt_tx_val === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL tx_extra cyc=%0d: got word %h, expected none", cyc, pkt_tx_data);
         end else begin
            w = exp_q.pop_front();
            if ({pkt_tx_data, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod} !== {w.data, w.sop, w.eop, w.mod}) begin
               errors++;
               $display("FAIL tx_word cyc=%0d: got %h sop=%b eop=%b mod=%0d, expected %h sop=%b eop=%b mod=%0d",
                        cyc, pkt_tx_data, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod, w.data, w.sop, w.eop, w.mod);
            end
            last_data = w.data; last_sop = w.sop; last_eop = w.eop; last_mod = w.mod;
            tx_words++;
            if (first_tx_cyc < 0) first_tx_cyc = cyc;
            if (w.eop) begin
               exp_frames++;
               if (w.err) exp_err_frames++;
               if (w.mod == 3'd1) eop_mod1++;
            end
         end
      end else begin
         checks++;
         if ({pkt_tx_data, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod} !== {last_data, last_sop, last_eop, last_mod}) begin
            errors++;
            $display("FAIL tx_hold cyc=%0d: got %h/%b/%b/%0d, expected %h/%b/%b/%0d", cyc, pkt_tx_data,
                     pkt_tx_sop, pkt_tx_eop, pkt_tx_mod, last_data, last_sop, last_eop, last_mod);
         end
      end
      exp_ren = m_reading && !(pkt_rx_val && pkt_rx_eop) && (m_occ <= DEPTH - 3);
      checks++;
      if (pkt_rx_ren !== exp_ren) begin
         errors++;
         $display("FAIL rx_ren cyc=%0d: got %b, expected %b (occupancy %0d)", cyc, pkt_rx_ren, exp_ren, m_occ);
      end
      checks++;
      if (busy !== (m_reading || m_occ > 0)) begin
         errors++;
         $display("FAIL busy cyc=%0d: got %b, expected %b", cyc, busy, (m_reading || m_occ > 0));
      end
      checks++;
      if (stat_frames !== (STATS ? 32'(exp_frames) : 32'd0) ||
          stat_err_frames !== (STATS ? 32'(exp_err_frames) : 32'd0)) begin
         errors++;
         $display("FAIL stats cyc=%0d: got %0d/%0d, expected %0d/%0d", cyc, stat_frames, stat_err_frames,
                  STATS ? exp_frames : 0, STATS ? exp_err_frames : 0);
      end
      checks++;
      if (m_occ > DEPTH) begin
         errors++;
         $display("FAIL overflow cyc=%0d: occupancy %0d, expected at most %0d", cyc, m_occ, DEPTH);
      end
      ren_s = (pkt_rx_ren === 1'b1);
      if (ren_s) begin
         ren_cycles++;
         if (first_ren_cyc < 0) first_ren_cyc = cyc;
         last_ren_cyc = cyc;
      end
      if (m_reading && !ren_s && !(pkt_rx_val && pkt_rx_eop)) stall_cycles++;
      pop_now = (m_occ > 0) && !pkt_tx_full;
      if (pkt_rx_val) begin
         exp_q.push_back('{data: pkt_rx_data, sop: pkt_rx_sop, eop: pkt_rx_eop, mod: pkt_rx_mod, err: pkt_rx_err});
         rx_words++;
         if (first_rx_cyc < 0) first_rx_cyc = cyc;
      end
      m_occ   = m_occ + int'(pkt_rx_val) - int'(pop_now);
      exp_txv = pop_now;
      if (!m_reading) m_reading = loopback_en && pkt_rx_avail;
      else if (pkt_rx_val && pkt_rx_eop) m_reading = 1'b0;
      @(posedge clk);
      #1;
      cyc++;
      if (ren_s) begin
         checks++;
         if (mac_q.size() == 0) begin
            errors++;
            $display("FAIL mac_read cyc=%0d: read issued with %0d words left, expected no read", cyc, 0);
            drive_idle();
         end else begin
            w = mac_q.pop_front();
            pkt_rx_val  = 1'b1;
            pkt_rx_data = w.data;
            pkt_rx_sop  = w.sop;
            pkt_rx_eop  = w.eop;
            pkt_rx_mod  = w.mod;
            pkt_rx_err  = w.err;
         end
      end else begin
         drive_idle();
      end
      pkt_rx_avail = (mac_q.size() > 0);
   endtask

   // One-cycle synchronous reset; the MAC drops the rest of any partially read frame.
   task automatic do_reset();
      reset_156m25_n = 1'b0;
      @(posedge clk);
      #1;
      cyc++;
      reset_156m25_n = 1'b1;
      drive_idle();
      while (mac_q.size() > 0 && !mac_q[0].sop) mac_q.delete(0);
      exp_q.delete();
      m_reading = 1'b0; m_occ = 0; exp_txv = 1'b0;
      last_data = '0; last_sop = 1'b0; last_eop = 1'b0; last_mod = '0;
      exp_frames = 0; exp_err_frames = 0;
      pkt_rx_avail = (mac_q.size() > 0);
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while ((mac_q.size() > 0 || exp_q.size() > 0 || m_reading || m_occ > 0 || exp_txv) && n < budget) begin
         cycle();
         n++;
      end
      checks++;
      if (n >= budget) begin
         errors++;
         $display("FAIL drain_timeout: still pending after %0d cycles, expected idle", n);
      end
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({pkt_tx_val, pkt_tx_sop, pkt_tx_eop, pkt_tx_data, pkt_tx_mod, stat_frames, stat_err_frames} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got val=%b data=%h stats=%0d/%0d, expected all 0", pkt_tx_val, pkt_tx_data,
                  stat_frames, stat_err_frames);
      end
      checks++;
      if ({pkt_rx_ren, busy} !== 2'b00) begin
         errors++;
         $display("FAIL reset_ren_busy: got ren=%b busy=%b, expected 0 0", pkt_rx_ren, busy);
      end
   endtask

   task automatic test_basic();
      reset_counters();
      loopback_en = 1'b1;
      add_frame(8, 3'd0, 1'b0);
      drain(200);
      checks++;
      if (ren_cycles != 8) begin
         errors++; $display("FAIL basic_ren_cycles: got %0d, expected 8", ren_cycles);
      end
      checks++;
      if (tx_words != 8) begin
         errors++; $display("FAIL basic_tx_words: got %0d, expected 8", tx_words);
      end
      checks++;
      if (first_tx_cyc - first_rx_cyc != 2) begin
         errors++; $display("FAIL basic_latency: got %0d, expected 2", first_tx_cyc - first_rx_cyc);
      end
   endtask

   task automatic test_enable();
      reset_counters();
      loopback_en = 1'b0;
      add_frame(3, 3'($urandom_range(0, 7)), 1'b0);
      repeat (50) cycle();
      checks++;
      if (ren_cycles != 0 || busy !== 1'b0) begin
         errors++; $display("FAIL enable_off: got ren_cycles=%0d busy=%b, expected 0 0", ren_cycles, busy);
      end
      loopback_en = 1'b1;
      cycle();
      checks++;
      if (ren_s !== 1'b0) begin
         errors++; $display("FAIL enable_same_cycle: got ren=%b, expected 0", ren_s);
      end
      cycle();
      checks++;
      if (ren_s !== 1'b1) begin
         errors++; $display("FAIL enable_next_cycle: got ren=%b, expected 1", ren_s);
      end
      drain(200);
   endtask

   task automatic test_backpressure();
      int n0;
      reset_counters();
      add_frame(188, 3'd4, 1'b0);
      repeat (60) cycle();
      pkt_tx_full = 1'b1;
      cycle();
      n0 = tx_words;
      repeat (19) cycle();
      pkt_tx_full = 1'b0;
      cycle();
      checks++;
      if (tx_words != n0) begin
         errors++; $display("FAIL bp_tx_during_full: got %0d words, expected 0", tx_words - n0);
      end
      drain(1000);
      checks++;
      if (tx_words != 188) begin
         errors++; $display("FAIL bp_tx_words: got %0d, expected 188", tx_words);
      end
      checks++;
      if (stall_cycles == 0) begin
         errors++; $display("FAIL bp_ren_stall: got %0d stall cycles, expected at least 1", stall_cycles);
      end
   endtask

   task automatic test_back_to_back();
      reset_counters();
      repeat (3) add_frame(2, 3'd1, 1'b0);
      drain(300);
      checks++;
      if (eop_mod1 != 3 || tx_words != 6) begin
         errors++; $display("FAIL b2b_frames: got eop_mod1=%0d words=%0d, expected 3 6", eop_mod1, tx_words);
      end
      // Per boundary: the eop-arrival cycle plus one IDLE cycle without a read.
      checks++;
      if (ren_cycles != 6 || last_ren_cyc - first_ren_cyc + 1 != 10) begin
         errors++; $display("FAIL b2b_ren_span: got %0d reads over %0d cycles, expected 6 over 10", ren_cycles,
                            last_ren_cyc - first_ren_cyc + 1);
      end
   endtask

   task automatic test_random();
      int total = 0;
      int n = 0;
      int len;
      reset_counters();
      for (int f = 0; f < 6; f++) begin
         len = $urandom_range(1, 24);
         total += len;
         add_frame(len, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      end
      while ((mac_q.size() > 0 || m_reading) && n < 3000) begin
         pkt_tx_full = ($urandom_range(0, 3) == 0);
         cycle();
         n++;
      end
      pkt_tx_full = 1'b0;
      drain(500);
      checks++;
      if (tx_words != total) begin
         errors++; $display("FAIL random_tx_words: got %0d, expected %0d", tx_words, total);
      end
   endtask

   task automatic test_stats();
      int n1, n2;
      do_reset();
      reset_counters();
      n1 = $urandom_range(1, 6);
      n2 = $urandom_range(1, 6);
      add_frame(n1, 3'($urandom_range(0, 7)), 1'b0);
      add_frame(n2, 3'($urandom_range(0, 7)), 1'b1);
      drain(300);
      checks++;
      if (tx_words != n1 + n2) begin
         errors++; $display("FAIL stats_tx_words: got %0d, expected %0d", tx_words, n1 + n2);
      end
      checks++;
      if (stat_frames !== (STATS ? 32'd2 : 32'd0) || stat_err_frames !== (STATS ? 32'd1 : 32'd0)) begin
         errors++;
         $display("FAIL stats_final: got %0d/%0d, expected %0d/%0d", stat_frames, stat_err_frames,
                  STATS ? 2 : 0, STATS ? 1 : 0);
      end
   endtask

   task automatic test_reset_mid();
      int n = 0;
      reset_counters();
      add_frame(10, 3'd2, 1'b0);
      while (rx_words < 3 && n < 100) begin
         cycle();
         n++;
      end
      checks++;
      if (rx_words < 3) begin
         errors++; $display("FAIL midreset_start: got %0d words, expected 3", rx_words);
      end
      repeat (1) cycle();
      do_reset();
      checks++;
      if ({pkt_tx_val, pkt_tx_sop, pkt_tx_eop, pkt_tx_data, pkt_tx_mod, pkt_rx_ren, busy} !== '0) begin
         errors++;
         $display("FAIL midreset_outputs: got val=%b data=%h ren=%b busy=%b, expected all 0", pkt_tx_val,
                  pkt_tx_data, pkt_rx_ren, busy);
      end
      reset_counters();
      add_frame(8, 3'($urandom_range(0, 7)), 1'b0);
      drain(200);
      checks++;
      if (tx_words != 8 || rx_words != 8) begin
         errors++; $display("FAIL midreset_next_frame: got rx=%0d tx=%0d, expected 8 8", rx_words, tx_words);
      end
   endtask

   initial begin
      reset_156m25_n = 1'b0;
      loopback_en    = 1'b0;
      pkt_rx_avail   = 1'b0;
      pkt_tx_full    = 1'b0;
      drive_idle();
      m_reading = 1'b0; m_occ = 0; exp_txv = 1'b0;
      last_data = '0; last_sop = 1'b0; last_eop = 1'b0; last_mod = '0;
      exp_frames = 0; exp_err_frames = 0;
      reset_counters();
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_basic();
      test_enable();
      test_backpressure();
      test_back_to_back();
      test_random();
      test_stats();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation still running at time %0t, expected completion", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
